// File: rtl/uart_rx_monitor.sv
// 8N1 receiver for the SoC UART tap. Decoded bytes go into a small FIFO that is
// drained through a valid/ready port. Framing and overflow errors are sticky.
module uart_rx_monitor #(
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16
) (
    input  logic                          clock,
    input  logic                          resetb,
    input  logic                          rx_line,
    input  logic [DIV_W-1:0]              clk_div,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   rx_level,
    output logic                          frame_err,
    output logic                          overflow,
    input  logic                          clr_err,
    output logic                          busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [2:0] {
        ST_BREAK, ST_IDLE, ST_START, ST_DATA, ST_STOP
    } state_t;

    state_t           r_state, w_next;
    logic [1:0]       r_sync;
    logic [1:0]       r_settle;
    logic [DIV_W-1:0] r_cnt, r_div;
    logic [2:0]       r_idx;
    logic [7:0]       r_shift;
    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [AW-1:0]    r_wptr, r_rptr;
    logic [LW-1:0]    r_level;
    logic             r_ferr, r_ovf;

    logic             w_s, w_tick, w_push, w_set_ferr;
    logic             w_pop, w_full, w_wr, w_drop;
    logic [DIV_W-1:0] w_div_eff, w_half;

    assign w_s       = r_sync[1];
    assign w_tick    = (r_cnt == DIV_W'(1));
    assign w_div_eff = (clk_div < DIV_W'(2)) ? DIV_W'(2) : clk_div;
    assign w_half    = w_div_eff >> 1;

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            r_sync   <= 2'b11;
            r_settle <= 2'b00;
        end else begin
            r_sync   <= {r_sync[0], rx_line};
            r_settle <= {r_settle[0], 1'b1};
        end
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) r_state <= ST_BREAK;
        else         r_state <= w_next;
    end

    // The synchronizer resets high, so BREAK ignores s until the flops hold real
    // line samples; otherwise a line held low through reset would look idle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_BREAK: if (r_settle[1] && w_s) w_next = ST_IDLE;
            ST_IDLE:  if (!w_s) w_next = ST_START;
            ST_START: if (w_tick) w_next = w_s ? ST_IDLE : ST_DATA;
            ST_DATA:  if (w_tick && r_idx == 3'd7) w_next = ST_STOP;
            ST_STOP:  if (w_tick) w_next = w_s ? ST_IDLE : ST_BREAK;
            default:  w_next = ST_BREAK;
        endcase
    end

    always_comb begin
        busy       = 1'b0;
        w_push     = 1'b0;
        w_set_ferr = 1'b0;
        case (r_state)
            ST_START, ST_DATA: busy = 1'b1;
            ST_STOP: begin
                busy       = 1'b1;
                w_push     = w_tick & w_s;
                w_set_ferr = w_tick & ~w_s;
            end
            default: ;
        endcase
    end

    // Bit timing: the counter expires when it reaches 1, so a load of N puts
    // the sample N cycles after the loading edge's cycle.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            r_cnt   <= '0;
            r_div   <= DIV_W'(2);
            r_idx   <= '0;
            r_shift <= '0;
        end else begin
            case (r_state)
                ST_IDLE: if (!w_s) begin
                    r_cnt <= w_half;
                    r_div <= w_div_eff;
                end
                ST_START: begin
                    r_cnt <= w_tick ? r_div : r_cnt - DIV_W'(1);
                    if (w_tick) r_idx <= '0;
                end
                ST_DATA: begin
                    r_cnt <= w_tick ? r_div : r_cnt - DIV_W'(1);
                    if (w_tick) begin
                        r_shift[r_idx] <= w_s;
                        r_idx          <= r_idx + 3'd1;
                    end
                end
                ST_STOP: if (!w_tick) r_cnt <= r_cnt - DIV_W'(1);
                default: ;
            endcase
        end
    end

    assign w_pop  = rx_valid & rx_ready;
    assign w_full = (r_level == LW'(FIFO_DEPTH));
    assign w_wr   = w_push & (~w_full | w_pop);
    assign w_drop = w_push & w_full & ~w_pop;

    always_ff @(posedge clock) begin
        if (w_wr) r_mem[r_wptr] <= r_shift;
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_wr)  r_wptr <= r_wptr + AW'(1);
            if (w_pop) r_rptr <= r_rptr + AW'(1);
            r_level <= r_level + LW'(w_wr) - LW'(w_pop);
        end
    end

    // A new error in the same cycle as clr_err takes priority.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            r_ferr <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            if (w_set_ferr)   r_ferr <= 1'b1;
            else if (clr_err) r_ferr <= 1'b0;
            if (w_drop)       r_ovf  <= 1'b1;
            else if (clr_err) r_ovf  <= 1'b0;
        end
    end

    assign rx_valid  = (r_level != '0);
    assign rx_level  = r_level;
    assign rx_data   = rx_valid ? r_mem[r_rptr] : 8'h00;
    assign frame_err = r_ferr;
    assign overflow  = r_ovf;
endmodule

// File: tb/tb_uart_rx_monitor.sv
// Directed bench for uart_rx_monitor: latency, glitch, framing error, overflow,
// full push/pop, reset mid-frame and divider clamp.
module tb_uart_rx_monitor;
    logic        clock = 1'b0;
    logic        resetb, rx_line, rx_ready, clr_err;
    logic [15:0] clk_div;
    logic [7:0]  rx_data;
    logic        rx_valid, frame_err, overflow, busy;
    logic [4:0]  rx_level;

    int errors = 0;
    int checks = 0;

    uart_rx_monitor #(.FIFO_DEPTH(16), .DIV_W(16)) dut (
        .clock(clock), .resetb(resetb), .rx_line(rx_line), .clk_div(clk_div),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .rx_level(rx_level), .frame_err(frame_err), .overflow(overflow),
        .clr_err(clr_err), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input int d, input logic stop);
        rx_line = 1'b0;
        tick(d);
        for (int i = 0; i < 8; i++) begin
            rx_line = b[i];
            tick(d);
        end
        rx_line = stop;
        tick(d);
    endtask

    task automatic pop(output logic [7:0] d);
        d = rx_data;
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
    endtask

    int         n;
    logic       b1, b2, got;
    logic [7:0] d, gd;

    initial begin
        resetb = 1'b0; rx_line = 1'b1; rx_ready = 1'b0; clr_err = 1'b0; clk_div = 16'd16;
        tick(3);
        chk("rst_valid", 32'(rx_valid), 32'd0);
        chk("rst_level", 32'(rx_level), 32'd0);
        chk("rst_data",  32'(rx_data),  32'd0);
        chk("rst_ferr",  32'(frame_err), 32'd0);
        chk("rst_ovf",   32'(overflow), 32'd0);
        chk("rst_busy",  32'(busy), 32'd0);
        resetb = 1'b1;
        tick(5);

        // single byte and latency from the pin edge
        n = 0;
        fork
            send(8'hA5, 16, 1'b1);
            while (!rx_valid && n < 400) begin tick(1); n++; end
        join
        chk("lat", 32'(n), 32'd155);
        chk("a5_data",  32'(rx_data),  32'hA5);
        chk("a5_level", 32'(rx_level), 32'd1);
        chk("a5_ferr",  32'(frame_err), 32'd0);
        chk("a5_ovf",   32'(overflow), 32'd0);
        pop(d);
        chk("a5_pop_level", 32'(rx_level), 32'd0);
        chk("a5_pop_valid", 32'(rx_valid), 32'd0);

        // glitch: 4-cycle low pulse
        rx_line = 1'b0;
        fork
            begin tick(4); rx_line = 1'b1; end
            begin tick(10); b1 = busy; tick(1); b2 = busy; end
        join
        chk("gl_busy_pre",  32'(b1), 32'd1);
        chk("gl_busy_post", 32'(b2), 32'd0);
        tick(20);
        chk("gl_valid", 32'(rx_valid), 32'd0);
        chk("gl_ferr",  32'(frame_err), 32'd0);

        // framing error, then line held low, then recovery
        send(8'h3C, 16, 1'b0);
        tick(50);
        chk("fe_busy_break", 32'(busy), 32'd0);
        rx_line = 1'b1;
        tick(20);
        chk("fe_ferr",  32'(frame_err), 32'd1);
        chk("fe_level", 32'(rx_level), 32'd0);
        send(8'h41, 16, 1'b1);
        tick(4);
        chk("fe_41_level", 32'(rx_level), 32'd1);
        chk("fe_41_data",  32'(rx_data), 32'h41);
        pop(d);
        clr_err = 1'b1; tick(1); clr_err = 1'b0;
        chk("fe_clr", 32'(frame_err), 32'd0);

        // overflow: 17 bytes, last one dropped
        for (int i = 0; i < 17; i++) send(8'(i), 16, 1'b1);
        tick(4);
        chk("ov_level", 32'(rx_level), 32'd16);
        chk("ov_flag",  32'(overflow), 32'd1);
        for (int i = 0; i < 16; i++) begin
            pop(d);
            chk("ov_pop", 32'(d), 32'(i));
        end
        chk("ov_empty", 32'(rx_valid), 32'd0);
        rx_ready = 1'b1;
        got = 1'b0; gd = 8'h00; n = 0;
        fork
            send(8'h55, 16, 1'b1);
            while (!got && n < 200) begin
                if (rx_valid) begin gd = rx_data; got = 1'b1; end
                else begin tick(1); n++; end
            end
        join
        tick(2);
        rx_ready = 1'b0;
        chk("st_got",   32'(got), 32'd1);
        chk("st_data",  32'(gd), 32'h55);
        chk("st_level", 32'(rx_level), 32'd0);
        clr_err = 1'b1; tick(1); clr_err = 1'b0;
        chk("ov_clr", 32'(overflow), 32'd0);

        // full FIFO with push and pop on the same edge
        for (int i = 0; i < 16; i++) send(8'h60 + 8'(i), 16, 1'b1);
        tick(1);
        chk("fp_fill", 32'(rx_level), 32'd16);
        fork
            send(8'h77, 16, 1'b1);
            begin tick(154); rx_ready = 1'b1; tick(1); rx_ready = 1'b0; end
        join
        tick(4);
        chk("fp_level", 32'(rx_level), 32'd16);
        chk("fp_ovf",   32'(overflow), 32'd0);
        for (int i = 0; i < 16; i++) begin
            pop(d);
            chk("fp_pop", 32'(d), (i < 15) ? 32'(8'h61 + 8'(i)) : 32'h77);
        end
        chk("fp_empty", 32'(rx_valid), 32'd0);

        // reset during DATA bit 3 with the line low
        send(8'h12, 16, 1'b1);
        tick(2);
        chk("rm_pre_level", 32'(rx_level), 32'd1);
        rx_line = 1'b0;
        tick(16 + 48 + 8);
        chk("rm_busy_mid", 32'(busy), 32'd1);
        resetb = 1'b0;
        tick(2);
        chk("rm_rst_level", 32'(rx_level), 32'd0);
        chk("rm_rst_busy",  32'(busy), 32'd0);
        resetb = 1'b1;
        tick(100);
        chk("rm_low_valid", 32'(rx_valid), 32'd0);
        chk("rm_low_busy",  32'(busy), 32'd0);
        chk("rm_low_ferr",  32'(frame_err), 32'd0);
        rx_line = 1'b1;
        tick(10);
        clk_div = 16'd1;
        send(8'h5A, 2, 1'b1);
        tick(10);
        chk("dc_valid", 32'(rx_valid), 32'd1);
        chk("dc_data",  32'(rx_data), 32'h5A);
        chk("dc_level", 32'(rx_level), 32'd1);
        chk("dc_ferr",  32'(frame_err), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
